// File: rtl/vr_master.sv
// Valid/ready transmitter: producer pushes into a DEPTH-entry FIFO that feeds a registered bus word.
// Define VR_MASTER_TXCNT_EN to add the tx_count handshake counter port.
module vr_master #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16,
    localparam int LW       = $clog2(DEPTH + 1),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 full,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 valid,
    input  logic                 ready,
    output logic [WIDTH-1:0]     data_out
`ifdef VR_MASTER_TXCNT_EN
    ,
    output logic [CNT_WIDTH-1:0] tx_count
`endif
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               handshake;
    logic [LW-1:0]      level_next;

    // Valid/ready: a word transfers on any posedge where valid && ready; once valid is
    // raised, valid and data_out hold steady until that transfer happens.
    always_comb begin
        handshake  = valid && ready;
        push       = wr_en && !full;
        pop        = 1'b0;
        level_next = level;
        case (state)
            IDLE:    pop = en && (level != '0);
            SEND:    pop = handshake && en && (level != '0);
            default: pop = 1'b0;
        endcase
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            data_out <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // full is the registered view of level, so a same-cycle pop never admits a push.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            case (state)
                IDLE: begin
                    if (pop) begin
                        valid <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (handshake && !pop) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VR_MASTER_TXCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count <= '0;
        end else if (handshake) begin
            tx_count <= tx_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vr_master.sv
// Directed bench for vr_master: reset, single word, backpressure, streaming, overflow, en/reset mid-op.
// Inputs change 1ns after posedge; outputs are checked at that same point.
module tb_vr_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [2:0]  level;
    logic        overflow;
    logic        valid;
    logic        ready;
    logic [7:0]  data_out;
`ifdef VR_MASTER_TXCNT_EN
    logic [15:0] tx_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vr_master #(.WIDTH(8), .DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .valid    (valid),
        .ready    (ready),
        .data_out (data_out)
`ifdef VR_MASTER_TXCNT_EN
        ,
        .tx_count (tx_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ready = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            en      = 1'($urandom_range(0, 1));
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom_range(0, 255));
            ready   = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_level", 32'(level), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
`ifdef VR_MASTER_TXCNT_EN
        check("rst_txcnt", 32'(tx_count), 0);
`endif
        rst = 1'b0; en = 1'b1; ready = 1'b1; wr_en = 1'b0;

        // 2: single word
        push_word(8'hA5);
        check("single_c0_valid", 32'(valid), 0);
        check("single_c0_level", 32'(level), 1);
        tick();
        check("single_c1_valid", 32'(valid), 1);
        check("single_c1_data", 32'(data_out), 32'hA5);
        check("single_c1_level", 32'(level), 0);
        tick();
        check("single_c2_valid", 32'(valid), 0);
        check("single_c2_hold", 32'(data_out), 32'hA5);

        // 3: backpressure
        ready = 1'b0;
        push_word(8'h3C);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(valid), 1);
            check("bp_data", 32'(data_out), 32'h3C);
            tick();
        end
        ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(valid), 0);

        // 4: streaming, one word per cycle
        push_word(8'h01);
        push_word(8'h02);
        check("stream_v1", 32'(valid), 1);
        check("stream_d1", 32'(data_out), 32'h01);
        push_word(8'h03);
        check("stream_v2", 32'(valid), 1);
        check("stream_d2", 32'(data_out), 32'h02);
        push_word(8'h04);
        check("stream_v3", 32'(valid), 1);
        check("stream_d3", 32'(data_out), 32'h03);
        tick();
        check("stream_v4", 32'(valid), 1);
        check("stream_d4", 32'(data_out), 32'h04);
        tick();
        check("stream_end_valid", 32'(valid), 0);

        // 5: overflow
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_word(8'(8'h10 + i));
        end
        check("ovf_level", 32'(level), 4);
        check("ovf_full", 32'(full), 1);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_noload", 32'(valid), 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovf_drain_valid", 32'(valid), 1);
            check("ovf_drain_data", 32'(data_out), 32'(8'h10 + i));
        end
        check("ovf_drain_level", 32'(level), 0);
        tick();
        check("ovf_drain_end", 32'(valid), 0);
        check("ovf_still_set", 32'(overflow), 1);

        // 6: en dropped mid-transfer, then reset while valid
        ready = 1'b0;
        push_word(8'h20);
        push_word(8'h21);
        check("mid_valid", 32'(valid), 1);
        check("mid_data", 32'(data_out), 32'h20);
        en = 1'b0;
        tick();
        tick();
        check("mid_hold_valid", 32'(valid), 1);
        check("mid_hold_data", 32'(data_out), 32'h20);
        ready = 1'b1;
        tick();
        check("mid_idle_valid", 32'(valid), 0);
        check("mid_idle_level", 32'(level), 1);
        check("mid_idle_data", 32'(data_out), 32'h20);
        ready = 1'b0; en = 1'b1;
        tick();
        check("mid_reload_valid", 32'(valid), 1);
        check("mid_reload_data", 32'(data_out), 32'h21);
`ifdef VR_MASTER_TXCNT_EN
        check("txcnt_total", 32'(tx_count), 11);
`endif
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; ready = 1'b1;
        tick();
        check("midrst_valid", 32'(valid), 0);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_level", 32'(level), 0);
        check("midrst_full", 32'(full), 0);
        check("midrst_ovf", 32'(overflow), 0);
`ifdef VR_MASTER_TXCNT_EN
        check("midrst_txcnt", 32'(tx_count), 0);
`endif
        rst = 1'b0; wr_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
